// File: rtl/cb_config_loader.sv
// Serial configuration loader: assembles bit-serial words into connection-block
// config words, checks every routing field for a legal encoding, and commits
// all words to cbconfig at once only when the whole load is legal.
module cb_config_loader #(
  parameter int unsigned CB_WIDTH = 35,
  parameter int unsigned NUM_CB   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  output logic                         bit_ready,
  output logic [NUM_CB*CB_WIDTH-1:0]   cbconfig,
  output logic                         load_strobe,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [$clog2(NUM_CB)-1:0]    err_word,
  output logic [2:0]                   err_field
);

  localparam int unsigned FIELD_W    = 7;
  localparam int unsigned NUM_FIELDS = 5;
  localparam int unsigned WW         = $clog2(NUM_CB);
  localparam int unsigned BW         = $clog2(CB_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                      state;
  logic [CB_WIDTH-1:0]         sr;
  logic [BW-1:0]               bit_cnt;
  logic [WW-1:0]               word_cnt;
  logic [CB_WIDTH-1:0]         staging [NUM_CB];
  logic [NUM_FIELDS-1:0]       field_ok;
  logic [2:0]                  first_bad;
  logic [NUM_CB*CB_WIDTH-1:0]  commit_bus;

  // A field is off, or selects exactly one track and enables at least one BLE
  function automatic logic field_legal(input logic [FIELD_W-1:0] f);
    logic [4:0] sel;
    sel = f[5:1];
    return (f == 7'd0) ||
           ((sel != 5'd0) && ((sel & (sel - 5'd1)) == 5'd0) && (f[6] | f[0]));
  endfunction

  // Per-field legality of the assembled word; lowest illegal field wins
  always_comb begin
    field_ok  = '0;
    first_bad = '0;
    for (int f = NUM_FIELDS - 1; f >= 0; f--) begin
      field_ok[f] = field_legal(sr[f*FIELD_W +: FIELD_W]);
      if (!field_ok[f]) first_bad = 3'(f);
    end
  end

  // Commit image: staged words plus the final word still sitting in sr
  always_comb begin
    commit_bus = '0;
    for (int unsigned k = 0; k < NUM_CB; k++) begin
      commit_bus[k*CB_WIDTH +: CB_WIDTH] = (k == NUM_CB - 1) ? sr : staging[k];
    end
  end

  // Load FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      sr          <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      cbconfig    <= '0;
      bit_ready   <= 1'b0;
      load_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_word    <= '0;
      err_field   <= '0;
      for (int unsigned k = 0; k < NUM_CB; k++) staging[k] <= '0;
    end else begin
      load_strobe <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state     <= S_SHIFT;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            error     <= 1'b0;
            done      <= 1'b0;
            err_word  <= '0;
            err_field <= '0;
            bit_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (bit_valid && bit_ready) begin
            sr <= {sr[CB_WIDTH-2:0], bit_in};
            if (bit_cnt == BW'(CB_WIDTH - 1)) begin
              bit_cnt   <= '0;
              bit_ready <= 1'b0;
              state     <= S_CHECK;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        S_CHECK: begin
          if (&field_ok) begin
            staging[word_cnt] <= sr;
            word_cnt          <= word_cnt + WW'(1);
            if (word_cnt == WW'(NUM_CB - 1)) begin
              cbconfig    <= commit_bus;
              load_strobe <= 1'b1;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= S_DONE;
            end else begin
              bit_ready <= 1'b1;
              state     <= S_SHIFT;
            end
          end else begin
            error     <= 1'b1;
            busy      <= 1'b0;
            err_word  <= word_cnt;
            err_field <= first_bad;
            state     <= S_ERROR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
